lfsr_pkt_decoder: RTL and testbench
===================================

Name: lfsr_pkt_decoder

Overview:
Parametrised successor to the fixed 6-candidate, 5-bit LFSR packet decryptor. It has an integrated control FSM and a valid/ready stream interface on both sides. It derives the LFSR seed from the first encrypted byte, runs N candidate tap polynomials in parallel through a configurable-length preamble, and keeps a sticky match bit per candidate. It then decrypts the payload with the lowest-index surviving candidate, or discards the packet and flags an error when no candidate survives. It sits between the byte-input FIFO and the plaintext consumer.

Parameters:
DW, 8, data byte width
LW, 5, LFSR width (LW <= DW)
NCAND, 6, number of candidate tap polynomials
TAPS, {5'h12,5'h14,5'h17,5'h1B,5'h1D,5'h1E}, packed NCAND*LW; candidate i = TAPS[i*LW +: LW]; index 0 = 5'h1E
PRE_LEN, 7, preamble length in bytes (>=2)
PKT_LEN, 32, total packet length in bytes including preamble (> PRE_LEN)
PRE_BYTE, 8'h7E, plaintext preamble value

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_data  in  DW  encrypted byte
in_valid  in  1  in_data valid
in_ready  out  1  block accepts in_data this cycle
out_data  out  DW  decrypted payload byte (registered)
out_valid  out  1  out_data valid
out_ready  in  1  consumer accepts out_data
pkt_done  out  1  1-cycle pulse when the last byte of a packet is accepted
err  out  1  1-cycle pulse at end of preamble when no candidate matched
match_vec  out  NCAND  sticky match bits (held until the next packet starts)
sel_idx  out  $clog2(NCAND)  selected candidate index, valid in PAYLOAD state

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, byte_cnt=0, match_vec all ones, sel_idx=0, out_valid=0, out_data=0, pkt_done=0, err=0, all LFSR states 0.
- Input handshake: accept when in_valid & in_ready.
  - in_ready = ~out_valid | out_ready in PAYLOAD.
  - in_ready = 1 in IDLE, PREAMBLE and DISCARD.
- LFSR step: next = {state[LW-2:0], ^(state & tap_i)}. Keystream byte = zero-extended state.
- IDLE, on accept (preamble byte 0):
  - seed = (in_data ^ PRE_BYTE)[LW-1:0].
  - Every LFSR loads seed and then steps once, in the same edge: state <= step(seed).
  - match_vec <= all ones; byte_cnt <= 1; go to PREAMBLE.
  - If in_data[DW-1:LW] != PRE_BYTE[DW-1:LW], match_vec <= 0.
- PREAMBLE, on accept:
  - match[i] <= match[i] & ((in_data ^ ks_i) == PRE_BYTE); all LFSRs step; byte_cnt++.
  - On accept of byte PRE_LEN-1, evaluate the next match_vec (including this byte's compare):
    - Nonzero: sel_idx <= lowest set index; go to PAYLOAD.
    - Zero: err pulses next cycle; go to DISCARD.
- PAYLOAD, on accept:
  - out_data <= in_data ^ ks_sel; out_valid <= 1; all LFSRs step; byte_cnt++.
  - Output latency is 1 cycle from accept.
  - out_valid clears on out_ready when no new accept occurs; accept and drain may happen in the same cycle.
- DISCARD, on accept: byte_cnt++; no output; LFSRs hold.
- End of packet: on accept of byte PKT_LEN-1 (PAYLOAD or DISCARD):
  - pkt_done pulses next cycle; byte_cnt <= 0; go to IDLE.
  - The next byte starts a new packet with no bubble.
- Back-pressure: an out_valid byte stalls while out_ready=0, and in_ready=0 while it stalls. LFSRs and byte_cnt advance only on accept.
- byte_cnt width is $clog2(PKT_LEN). It never wraps within a packet.
- Seed 0: LFSRs stay locked at 0. Candidate behaviour follows the rules above with no special case (all may match; sel=0).
- Asynchronous reset mid-packet: all state is discarded immediately, including any pending out_data; the next accepted byte is treated as preamble byte 0.

Decomposition:
- Package lfsr_pkt_pkg holds:
  - state enum: IDLE, PREAMBLE, PAYLOAD, DISCARD;
  - default PRE_BYTE, PRE_LEN and PKT_LEN constants;
  - default TAPS constant;
  - step function lfsr_next(state, taps).
- Sub-module lfsr_nb (parametrised LW, with init/en/taps/start/state), instantiated NCAND times via generate.
- Priority select and sticky match logic stay in the top module.

Test Plan:
- Seed 5'h09 with candidate 2 (5'h1B); encode 7x 8'h7E + 25 payload bytes 0x00..0x18 (first encrypted byte 8'h77).
  -> match_vec = 6'b000100 after preamble, sel_idx = 2, out_data = 0x00..0x18, one pkt_done, err = 0.
- Corrupt preamble byte 4 so no candidate matches.
  -> err pulses once, 25 bytes consumed with out_valid = 0, pkt_done pulses, next packet decodes correctly.
- Hold out_ready = 0 for 10 cycles mid-payload.
  -> out_data held stable, in_ready = 0, no byte lost or duplicated; all 25 bytes still decoded in order.
- Two back-to-back packets with different seeds/taps (in_valid = 1 continuously).
  -> both decode, pkt_done twice, match_vec refreshed at packet 2 byte 0.
- Assert rst = 0 asynchronously at payload byte 10, release, then send a fresh packet.
  -> outputs are at reset values during reset; the fresh packet decodes fully.
- Parameter sweep LW = 7, NCAND = 4, PRE_LEN = 4, PKT_LEN = 16 against the reference model.
  -> bit-exact match.

Source files
------------

// File: rtl/lfsr_pkt_pkg.sv
// Shared types and defaults for the LFSR packet decoder.
// lfsr_next works at a fixed maximum width; callers zero-extend and truncate to their LFSR width.
package lfsr_pkt_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      PAYLOAD  = 2'd2,
      DISCARD  = 2'd3
   } pkt_state_t;

   localparam int LFSR_MAXW = 16;

   localparam logic [7:0]  PRE_BYTE_DEF = 8'h7E;
   localparam int          PRE_LEN_DEF  = 7;
   localparam int          PKT_LEN_DEF  = 32;
   localparam logic [29:0] TAPS_DEF     = {5'h12, 5'h14, 5'h17, 5'h1B, 5'h1D, 5'h1E};

   // Bits of state above the caller's LFSR width must be zero so they do not disturb the feedback.
   function automatic logic [LFSR_MAXW-1:0] lfsr_next(
      input logic [LFSR_MAXW-1:0] state,
      input logic [LFSR_MAXW-1:0] taps
   );
      return {state[LFSR_MAXW-2:0], ^(state & taps)};
   endfunction

endpackage

// File: rtl/lfsr_pkt_decoder_lfsr_nb.sv
// One candidate Fibonacci LFSR: load-and-step from i_start on i_init, step on i_en, else hold.
module lfsr_nb
   import lfsr_pkt_pkg::*;
#(
   parameter int LW = 5
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_init,
   input  logic          i_en,
   input  logic [LW-1:0] i_taps,
   input  logic [LW-1:0] i_start,
   output logic [LW-1:0] o_state
);

   logic [LW-1:0] r_state;
   logic [LW-1:0] w_base;

   assign w_base = i_init ? i_start : r_state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= '0;
      end else if (i_init | i_en) begin
         r_state <= LW'(lfsr_next(LFSR_MAXW'(w_base), LFSR_MAXW'(i_taps)));
      end
   end

   assign o_state = r_state;

endmodule

// File: rtl/lfsr_pkt_decoder.sv
// Packet decryptor: seeds NCAND candidate LFSRs from byte 0, keeps sticky preamble matches,
// then decrypts the payload with the lowest-index survivor or discards the packet with err.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for byte 0; seeds every LFSR on accept
//   PREAMBLE | comparing decrypted bytes against PRE_BYTE, stepping LFSRs
//   PAYLOAD  | emitting in_data ^ keystream of the selected candidate
//   DISCARD  | no candidate survived; swallowing the rest of the packet
module lfsr_pkt_decoder
   import lfsr_pkt_pkg::*;
#(
   parameter int                   DW       = 8,
   parameter int                   LW       = 5,
   parameter int                   NCAND    = 6,
   parameter logic [NCAND*LW-1:0]  TAPS     = TAPS_DEF,
   parameter int                   PRE_LEN  = PRE_LEN_DEF,
   parameter int                   PKT_LEN  = PKT_LEN_DEF,
   parameter logic [DW-1:0]        PRE_BYTE = PRE_BYTE_DEF,
   localparam int                  SW       = (NCAND > 1) ? $clog2(NCAND) : 1,
   localparam int                  CW       = $clog2(PKT_LEN)
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [DW-1:0]    in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [DW-1:0]    out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             pkt_done,
   output logic             err,
   output logic [NCAND-1:0] match_vec,
   output logic [SW-1:0]    sel_idx
);

   pkt_state_t       r_state;
   logic [CW-1:0]    r_cnt;
   logic [NCAND-1:0] r_match;
   logic [SW-1:0]    r_sel;
   logic [DW-1:0]    r_out_data;
   logic             r_out_valid;
   logic             r_pkt_done;
   logic             r_err;

   logic             w_accept;
   logic             w_init;
   logic             w_step;
   logic             w_hdr_ok;
   logic             w_last;
   logic             w_pre_last;
   logic [DW-1:0]    w_pre_xor;
   logic [LW-1:0]    w_seed;
   logic [LW-1:0]    w_ks [NCAND];
   logic [NCAND-1:0] w_cmp;
   logic [NCAND-1:0] w_match_nxt;
   logic [SW-1:0]    w_sel_nxt;
   logic [LW-1:0]    w_ks_sel;

   assign in_ready   = (r_state == PAYLOAD) ? (~r_out_valid | out_ready) : 1'b1;
   assign w_accept   = in_valid & in_ready;
   assign w_init     = w_accept & (r_state == IDLE);
   assign w_step     = w_accept & ((r_state == PREAMBLE) | (r_state == PAYLOAD));
   assign w_last     = (r_cnt == CW'(PKT_LEN - 1));
   assign w_pre_last = (r_cnt == CW'(PRE_LEN - 1));

   // Byte 0 is PRE_BYTE xor the zero-extended seed, so its upper bits must equal PRE_BYTE's.
   assign w_pre_xor  = in_data ^ PRE_BYTE;
   assign w_seed     = w_pre_xor[LW-1:0];
   assign w_hdr_ok   = ((w_pre_xor >> LW) == '0);

   for (genvar gi = 0; gi < NCAND; gi++) begin : g_cand
      lfsr_nb #(.LW(LW)) u_lfsr (
         .clk     (clk),
         .rst     (rst),
         .i_init  (w_init),
         .i_en    (w_step),
         .i_taps  (TAPS[gi*LW +: LW]),
         .i_start (w_seed),
         .o_state (w_ks[gi])
      );
      assign w_cmp[gi] = ((in_data ^ DW'(w_ks[gi])) == PRE_BYTE);
   end

   assign w_match_nxt = r_match & w_cmp;

   always_comb begin
      w_sel_nxt = '0;
      for (int i = NCAND - 1; i >= 0; i--) begin
         if (w_match_nxt[i]) w_sel_nxt = SW'(i);
      end
   end

   always_comb begin
      w_ks_sel = '0;
      for (int i = 0; i < NCAND; i++) begin
         if (r_sel == SW'(i)) w_ks_sel = w_ks[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_match     <= '1;
         r_sel       <= '0;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_pkt_done  <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_pkt_done <= 1'b0;
         r_err      <= 1'b0;
         if (out_ready) r_out_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_match <= w_hdr_ok ? '1 : '0;
                  r_cnt   <= CW'(1);
                  r_state <= PREAMBLE;
               end
            end
            PREAMBLE: begin
               if (w_accept) begin
                  r_match <= w_match_nxt;
                  r_cnt   <= r_cnt + CW'(1);
                  if (w_pre_last) begin
                     if (|w_match_nxt) begin
                        r_sel   <= w_sel_nxt;
                        r_state <= PAYLOAD;
                     end else begin
                        r_err   <= 1'b1;
                        r_state <= DISCARD;
                     end
                  end
               end
            end
            PAYLOAD: begin
               if (w_accept) begin
                  r_out_data  <= in_data ^ DW'(w_ks_sel);
                  r_out_valid <= 1'b1;
                  r_cnt       <= r_cnt + CW'(1);
                  if (w_last) begin
                     r_pkt_done <= 1'b1;
                     r_cnt      <= '0;
                     r_state    <= IDLE;
                  end
               end
            end
            DISCARD: begin
               if (w_accept) begin
                  r_cnt <= r_cnt + CW'(1);
                  if (w_last) begin
                     r_pkt_done <= 1'b1;
                     r_cnt      <= '0;
                     r_state    <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign pkt_done  = r_pkt_done;
   assign err       = r_err;
   assign match_vec = r_match;
   assign sel_idx   = r_sel;

endmodule

// File: tb/tb_lfsr_pkt_decoder.sv
// Bench for lfsr_pkt_decoder: default instance (A) and a LW=7/NCAND=4/PRE_LEN=4/PKT_LEN=16 instance (B),
// directed table vectors plus random packets scored against an array-based reference model.
module tb_lfsr_pkt_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [7:0] in_data   = '0;
   logic       in_valid  = 1'b0;
   logic       out_ready = 1'b1;
   int         dsel      = 0;

   logic       a_in_valid, a_in_ready, a_out_valid, a_pkt_done, a_err;
   logic [7:0] a_out_data;
   logic [5:0] a_match;
   logic [2:0] a_sel;
   logic       b_in_valid, b_in_ready, b_out_valid, b_pkt_done, b_err;
   logic [7:0] b_out_data;
   logic [3:0] b_match;
   logic [1:0] b_sel;

   assign a_in_valid = in_valid & (dsel == 0);
   assign b_in_valid = in_valid & (dsel == 1);

   lfsr_pkt_decoder u_a (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .out_data(a_out_data), .out_valid(a_out_valid), .out_ready(out_ready),
      .pkt_done(a_pkt_done), .err(a_err), .match_vec(a_match), .sel_idx(a_sel)
   );

   lfsr_pkt_decoder #(
      .DW(8), .LW(7), .NCAND(4), .TAPS({7'h71, 7'h48, 7'h60, 7'h41}),
      .PRE_LEN(4), .PKT_LEN(16), .PRE_BYTE(8'h7E)
   ) u_b (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .out_data(b_out_data), .out_valid(b_out_valid), .out_ready(out_ready),
      .pkt_done(b_pkt_done), .err(b_err), .match_vec(b_match), .sel_idx(b_sel)
   );

   logic c_in_ready, c_out_valid, c_pkt_done, c_err;
   logic [7:0] c_out_data;
   int c_match, c_sel;
   assign c_in_ready  = (dsel == 1) ? b_in_ready  : a_in_ready;
   assign c_out_valid = (dsel == 1) ? b_out_valid : a_out_valid;
   assign c_pkt_done  = (dsel == 1) ? b_pkt_done  : a_pkt_done;
   assign c_err       = (dsel == 1) ? b_err       : a_err;
   assign c_out_data  = (dsel == 1) ? b_out_data  : a_out_data;
   assign c_match     = (dsel == 1) ? 32'(b_match) : 32'(a_match);
   assign c_sel       = (dsel == 1) ? 32'(b_sel)   : 32'(a_sel);

   int cfg_lw[2] = '{5, 7};
   int cfg_nc[2] = '{6, 4};
   int cfg_pl[2] = '{7, 4};
   int cfg_kl[2] = '{32, 16};
   int taps_t[2][6] = '{'{'h1E, 'h1D, 'h1B, 'h17, 'h14, 'h12}, '{'h41, 'h60, 'h48, 'h71, 0, 0}};
   int last_sel[2] = '{0, 0};

   int checks   = 0;
   int failures = 0;

   typedef struct { int m; int s; int e; } info_t;
   int    cur_pkt[32];
   int    exp_q[$];
   int    got_q[$];
   info_t exp_info[$];
   info_t got_info[$];
   int    err_cnt   = 0;
   bit    hold_pend = 1'b0;
   int    hold_val  = 0;

   typedef struct {
      int d; int cand; int seed; int corrupt; int hdrbad; int stall_at;
      int exp_m; int exp_s; int exp_e;
   } vec_t;
   vec_t vt[5];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic int mstep(input int s, input int t, input int lw);
      return ((s << 1) | ($countones(s & t) & 1)) & ((1 << lw) - 1);
   endfunction

   // Encrypt: byte 0 carries the seed, byte k uses the LFSR state after k steps.
   task automatic build_pkt(input int d, input int cand, input int seed, input int corrupt,
                            input int hdrbad, input int rnd);
      int s  = seed;
      int pt;
      cur_pkt[0] = 'h7E ^ seed;
      for (int k = 1; k < cfg_kl[d]; k++) begin
         s  = mstep(s, taps_t[d][cand], cfg_lw[d]);
         pt = (k < cfg_pl[d]) ? 'h7E : ((rnd != 0) ? int'($urandom_range(255)) : k - cfg_pl[d]);
         cur_pkt[k] = pt ^ s;
      end
      if (hdrbad != 0) cur_pkt[0] = cur_pkt[0] ^ 'h80;
      if (corrupt > 0) cur_pkt[corrupt] = cur_pkt[corrupt] ^ 'h21;
   endtask

   // Reference decoder: try every candidate over the whole preamble, pick the lowest survivor.
   task automatic model_pkt(input int d);
      int lw   = cfg_lw[d];
      int seed = (cur_pkt[0] ^ 'h7E) & ((1 << lw) - 1);
      bit hok  = (((cur_pkt[0] ^ 'h7E) >> lw) == 0);
      int mv   = 0;
      int sel  = -1;
      int se[6];
      int s;
      bit ok;
      info_t inf;
      for (int c = 0; c < cfg_nc[d]; c++) begin
         s  = seed;
         ok = hok;
         for (int k = 1; k < cfg_pl[d]; k++) begin
            s = mstep(s, taps_t[d][c], lw);
            if (((cur_pkt[k] ^ s) & 'hFF) != 'h7E) ok = 1'b0;
         end
         se[c] = s;
         if (ok) begin
            mv = mv | (1 << c);
            if (sel < 0) sel = c;
         end
      end
      if (sel < 0) begin
         inf = '{0, last_sel[d], 1};
      end else begin
         last_sel[d] = sel;
         inf = '{mv, sel, 0};
         s = se[sel];
         for (int k = cfg_pl[d]; k < cfg_kl[d]; k++) begin
            s = mstep(s, taps_t[d][sel], lw);
            exp_q.push_back((cur_pkt[k] ^ s) & 'hFF);
         end
      end
      exp_info.push_back(inf);
   endtask

   task automatic drive_pkt(input int len, input int gap_pct, input int rdy_pct,
                            input int stall_at, input int stall_len);
      int i = 0;
      int guard = 0;
      int stalled = 0;
      bit in_stall;
      while (i < len && guard < 3000) begin
         @(negedge clk);
         guard++;
         in_valid = (int'($urandom_range(99)) >= gap_pct);
         in_data  = cur_pkt[i][7:0];
         in_stall = (stall_at >= 0) && (i == stall_at) && (stalled < stall_len);
         if (in_stall) begin
            out_ready = 1'b0;
            stalled++;
         end else begin
            out_ready = (int'($urandom_range(99)) < rdy_pct);
         end
         #1;
         if (in_stall && c_out_valid) chk("stall_in_ready", c_in_ready, 0);
         if (in_valid && c_in_ready) i++;
      end
      if (i < len) chk("drive_timeout", i, len);
   endtask

   task automatic drain();
      int n = 0;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      repeat (4) @(negedge clk);
      while (c_out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      #2;
      if (c_out_valid) chk("drain_timeout", 1, 0);
   endtask

   task automatic compare_sb(input string nm);
      int n;
      chk({nm, "_nbytes"}, got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) chk({nm, "_byte"}, got_q[i], exp_q[i]);
      chk({nm, "_npkts"}, got_info.size(), exp_info.size());
      n = (got_info.size() < exp_info.size()) ? got_info.size() : exp_info.size();
      for (int i = 0; i < n; i++) begin
         chk({nm, "_match"}, got_info[i].m, exp_info[i].m);
         chk({nm, "_sel"},   got_info[i].s, exp_info[i].s);
         chk({nm, "_err"},   got_info[i].e, exp_info[i].e);
      end
      got_q.delete();
      exp_q.delete();
      got_info.delete();
      exp_info.delete();
   endtask

   always @(negedge clk) begin
      #1;
      if (rst) begin
         if (hold_pend) begin
            chk("hold_valid", c_out_valid, 1);
            chk("hold_data", c_out_data, hold_val);
            hold_pend = 1'b0;
         end
         if (c_out_valid && out_ready) got_q.push_back(int'(c_out_data));
         if (c_out_valid && !out_ready) begin
            hold_pend = 1'b1;
            hold_val  = int'(c_out_data);
         end
         if (c_err) err_cnt++;
         if (c_pkt_done) begin
            got_info.push_back('{c_match, c_sel, err_cnt});
            err_cnt = 0;
         end
      end else begin
         hold_pend = 1'b0;
         err_cnt   = 0;
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout actual=running expected=finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      int cand, seed, corrupt, hdrbad;
      //        d cand seed corr hdr stall  match  sel err
      vt[0] = '{0, 2, 'h09, -1, 0, -1, 'h04, 2, 0};
      vt[1] = '{0, 2, 'h09,  4, 0, -1, 'h00, 2, 1};
      vt[2] = '{0, 2, 'h09, -1, 0, 17, 'h04, 2, 0};
      vt[3] = '{0, 3, 'h00, -1, 0, -1, 'h3F, 0, 0};
      vt[4] = '{0, 0, 'h05, -1, 1, -1, 'h00, 0, 1};

      #2 rst = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_out_data",  a_out_data, 0);
      chk("rst_a_match",     a_match, 'h3F);
      chk("rst_a_sel",       a_sel, 0);
      chk("rst_a_pkt_done",  a_pkt_done, 0);
      chk("rst_a_err",       a_err, 0);
      chk("rst_a_in_ready",  a_in_ready, 1);
      chk("rst_b_match",     b_match, 'hF);
      chk("rst_b_out_valid", b_out_valid, 0);
      @(negedge clk);
      #2 rst = 1'b1;

      for (int v = 0; v < 5; v++) begin
         dsel = vt[v].d;
         build_pkt(vt[v].d, vt[v].cand, vt[v].seed, vt[v].corrupt, vt[v].hdrbad, 0);
         model_pkt(vt[v].d);
         drive_pkt(cfg_kl[vt[v].d], 0, 100, vt[v].stall_at, 10);
         drain();
         chk("vec_npkts", got_info.size(), 1);
         if (got_info.size() > 0) begin
            chk("vec_match", got_info[0].m, vt[v].exp_m);
            chk("vec_sel",   got_info[0].s, vt[v].exp_s);
            chk("vec_err",   got_info[0].e, vt[v].exp_e);
         end
         if (vt[v].exp_e != 0) begin
            chk("vec_no_output", got_q.size(), 0);
         end else begin
            chk("vec_nbytes", got_q.size(), 25);
            for (int i = 0; i < got_q.size() && i < 25; i++) chk("vec_plain", got_q[i], i);
         end
         compare_sb("vec_model");
      end

      // Two packets back to back with continuous in_valid.
      build_pkt(0, 4, 'h13, -1, 0, 1);
      model_pkt(0);
      drive_pkt(32, 0, 100, -1, 0);
      build_pkt(0, 1, 'h1A, -1, 0, 1);
      model_pkt(0);
      drive_pkt(32, 0, 100, -1, 0);
      drain();
      compare_sb("b2b");

      for (int g = 0; g < 4; g++) begin
         for (int p = 0; p < 3; p++) begin
            cand    = int'($urandom_range(5));
            seed    = int'($urandom_range(31));
            corrupt = ($urandom_range(99) < 20) ? int'($urandom_range(6, 1)) : -1;
            hdrbad  = ($urandom_range(99) < 5) ? 1 : 0;
            build_pkt(0, cand, seed, corrupt, hdrbad, 1);
            model_pkt(0);
            drive_pkt(32, 25, 70, -1, 0);
         end
         drain();
         compare_sb("rand_a");
      end

      // Asynchronous reset at payload byte 10, then a fresh packet.
      build_pkt(0, 1, 'h0D, -1, 0, 1);
      drive_pkt(7 + 10, 0, 100, -1, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      chk("arst_out_valid", a_out_valid, 0);
      chk("arst_out_data",  a_out_data, 0);
      chk("arst_match",     a_match, 'h3F);
      chk("arst_sel",       a_sel, 0);
      chk("arst_pkt_done",  a_pkt_done, 0);
      chk("arst_in_ready",  a_in_ready, 1);
      got_q.delete();
      got_info.delete();
      last_sel[0] = 0;
      repeat (2) @(negedge clk);
      #2 rst = 1'b1;
      build_pkt(0, 5, 'h16, -1, 0, 1);
      model_pkt(0);
      drive_pkt(32, 10, 80, -1, 0);
      drain();
      compare_sb("post_rst");

      dsel = 1;
      build_pkt(1, 2, 'h00, -1, 0, 1);
      model_pkt(1);
      drive_pkt(16, 0, 100, -1, 0);
      drain();
      compare_sb("sweep_seed0");
      for (int g = 0; g < 4; g++) begin
         for (int p = 0; p < 3; p++) begin
            cand    = int'($urandom_range(3));
            seed    = int'($urandom_range(127));
            corrupt = ($urandom_range(99) < 20) ? int'($urandom_range(3, 1)) : -1;
            hdrbad  = ($urandom_range(99) < 5) ? 1 : 0;
            build_pkt(1, cand, seed, corrupt, hdrbad, 1);
            model_pkt(1);
            drive_pkt(16, 25, 70, 6 + p, 3);
         end
         drain();
         compare_sb("sweep");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
